// File: rtl/clk_div_bank.sv
// Synchronous clock-enable bank: binary-ratio square waves and strobes from one free-running
// counter, a masked AND of the selected stages, and one programmable divide-by-N channel.
module clk_div_bank #(
  parameter int unsigned Stages     = 4,
  parameter int unsigned DivW       = 8,
  parameter int unsigned DefaultDiv = 10
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              en_i,
  input  logic [Stages-1:0] mask_i,
  input  logic [DivW-1:0]   div_val_i,
  input  logic              load_i,
  output logic [Stages-1:0] div_out_o,
  output logic [Stages-1:0] div_tick_o,
  output logic              y_o,
  output logic              pdiv_out_o,
  output logic              pdiv_tick_o,
  output logic              busy_o
);

  logic [Stages-1:0] cnt_q, cnt_d;
  logic [Stages-1:0] tick_q, tick_d;
  logic              y_q, y_d;
  logic [DivW-1:0]   pcnt_q, pcnt_d;
  logic [DivW-1:0]   n_q, n_d;
  logic [DivW-1:0]   pend_q, pend_d;
  logic              busy_q, busy_d;
  logic              pdiv_q, pdiv_d;
  logic              ptick_q, ptick_d;
  logic              wrap;

  always_comb begin
    cnt_d  = en_i ? cnt_q + Stages'(1) : cnt_q;
    tick_d = en_i ? (cnt_d & ~cnt_q) : '0;
    // y follows the same registered count as div_out, so it only moves on enabled edges.
    y_d    = en_i ? ((mask_i != '0) && ((cnt_d & mask_i) == mask_i)) : y_q;

    wrap   = en_i && (pcnt_q == n_q - DivW'(1));
    pcnt_d = pcnt_q;
    n_d    = n_q;
    busy_d = busy_q;
    pend_d = pend_q;
    if (wrap) begin
      pcnt_d = '0;
      if (busy_q) begin
        n_d    = pend_q;
        busy_d = 1'b0;
      end
    end else if (en_i) begin
      pcnt_d = pcnt_q + DivW'(1);
    end
    // A load on the wrap edge lands after the swap above, so it waits for the next wrap.
    if (load_i) begin
      pend_d = (div_val_i < DivW'(2)) ? DivW'(2) : div_val_i;
      busy_d = 1'b1;
    end

    pdiv_d  = (pcnt_d >= (n_d >> 1));
    ptick_d = en_i && (pcnt_d == (n_d >> 1));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q   <= '0;
      tick_q  <= '0;
      y_q     <= 1'b0;
      pcnt_q  <= '0;
      n_q     <= DivW'(DefaultDiv);
      pend_q  <= '0;
      busy_q  <= 1'b0;
      pdiv_q  <= 1'b0;
      ptick_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      y_q     <= y_d;
      pcnt_q  <= pcnt_d;
      n_q     <= n_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      pdiv_q  <= pdiv_d;
      ptick_q <= ptick_d;
    end
  end

  assign div_out_o   = cnt_q;
  assign div_tick_o  = tick_q;
  assign y_o         = y_q;
  assign pdiv_out_o  = pdiv_q;
  assign pdiv_tick_o = ptick_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// Bench for clk_div_bank: arithmetic reference model compared every cycle, directed scenarios
// pinned with literal expectations, then randomized en/load/mask/reset traffic.
module tb_clk_div_bank;
  localparam int S   = 4;
  localparam int W   = 8;
  localparam int DEF = 10;

  logic         clk = 1'b0;
  logic         reset, en, load;
  logic [S-1:0] mask;
  logic [W-1:0] div_val;
  logic [S-1:0] div_out, div_tick;
  logic         y, pdiv_out, pdiv_tick, busy;

  clk_div_bank #(.Stages(S), .DivW(W), .DefaultDiv(DEF)) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .en_i       (en),
    .mask_i     (mask),
    .div_val_i  (div_val),
    .load_i     (load),
    .div_out_o  (div_out),
    .div_tick_o (div_tick),
    .y_o        (y),
    .pdiv_out_o (pdiv_out),
    .pdiv_tick_o(pdiv_tick),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state: enabled-cycle counts and ratios as plain integers.
  int m_cnt, m_p, m_n, m_pend;
  bit m_busy, e_y, e_ptick;
  int e_tick;

  task automatic model_step();
    if (reset) begin
      m_cnt = 0; m_p = 0; m_n = DEF; m_pend = 0; m_busy = 0;
      e_tick = 0; e_y = 0; e_ptick = 0;
    end else begin
      e_tick  = 0;
      e_ptick = 0;
      if (en) begin
        m_cnt = (m_cnt + 1) % (1 << S);
        for (int k = 0; k < S; k++)
          if ((m_cnt % (1 << (k + 1))) == (1 << k)) e_tick |= (1 << k);
        e_y = (mask != 0) && ((m_cnt & int'(mask)) == int'(mask));
        if (m_p == m_n - 1) begin
          m_p = 0;
          if (m_busy) begin
            m_n = m_pend;
            m_busy = 0;
          end
        end else begin
          m_p = m_p + 1;
        end
        e_ptick = (m_p == m_n / 2);
      end
      if (load) begin
        m_pend = (div_val < 2) ? 2 : int'(div_val);
        m_busy = 1;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("div_out", int'(div_out), m_cnt);
    chk("div_tick", int'(div_tick), e_tick);
    chk("y", int'(y), int'(e_y));
    chk("pdiv_out", int'(pdiv_out), int'(m_p >= m_n / 2));
    chk("pdiv_tick", int'(pdiv_tick), int'(e_ptick));
    chk("busy", int'(busy), int'(m_busy));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  int     hits;
  logic [5:0] pat;

  initial begin
    reset = 1'b1; en = 1'b0; load = 1'b0; mask = '0; div_val = '0;
    cyc();
    cyc();
    chk("reset_div_out", int'(div_out), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_pdiv_out", int'(pdiv_out), 0);

    // Free run: stage 3 ticks at 8, 24, 40; pdiv (N=10) first rises at cycle 5.
    reset = 1'b0; en = 1'b1; hits = 0;
    for (int c = 1; c <= 40; c++) begin
      cyc();
      if (div_tick[3]) hits++;
      if (c == 8)  chk("tick_at_8", int'(div_tick), 4'b1000);
      if (c == 5)  chk("ptick_at_5", int'(pdiv_tick), 1);
      if (c == 9)  chk("pdiv_hi_at_9", int'(pdiv_out), 1);
      if (c == 10) chk("pdiv_lo_at_10", int'(pdiv_out), 0);
    end
    chk("tick3_count", hits, 3);

    // Masked AND: 0101 is high for cnt in {5,7,13,15}.
    mask = 4'b0101; hits = 0;
    for (int c = 0; c < 16; c++) begin
      cyc();
      if (y) hits++;
    end
    chk("y_hits_0101", hits, 4);
    mask = 4'b0000; hits = 0;
    for (int c = 0; c < 16; c++) begin
      cyc();
      if (y) hits++;
    end
    chk("y_hits_0", hits, 0);

    // Load N=3 at pcnt=4: applied at wrap edge 10, then low 1 / high 2.
    do_reset();
    for (int c = 0; c < 4; c++) cyc();
    div_val = 8'd3; load = 1'b1;
    cyc();
    load = 1'b0;
    chk("busy_after_load", int'(busy), 1);
    for (int c = 0; c < 5; c++) cyc();
    chk("busy_clear_at_wrap", int'(busy), 0);
    pat = '0;
    for (int c = 0; c < 6; c++) begin
      cyc();
      pat = {pat[4:0], pdiv_out};
    end
    chk("n3_pattern", int'(pat), 6'b110110);

    // div_val=0 clamps to 2; then 255.
    div_val = 8'd0; load = 1'b1; cyc(); load = 1'b0;
    for (int c = 0; c < 30; c++) cyc();
    div_val = 8'd255; load = 1'b1; cyc(); load = 1'b0;
    for (int c = 0; c < 600; c++) cyc();

    // Two loads while busy: latest wins.
    div_val = 8'd6; load = 1'b1; cyc();
    div_val = 8'd7; cyc(); load = 1'b0;
    for (int c = 0; c < 300; c++) cyc();

    // Load exactly on a wrap edge: held one more full period of N=10.
    do_reset();
    for (int c = 0; c < 9; c++) cyc();
    div_val = 8'd4; load = 1'b1; cyc(); load = 1'b0;
    for (int c = 0; c < 9; c++) cyc();
    chk("wrap_load_still_busy", int'(busy), 1);
    cyc();
    chk("wrap_load_applied", int'(busy), 0);
    for (int c = 0; c < 12; c++) cyc();

    // Freeze for 7 cycles.
    en = 1'b0; hits = 0;
    for (int c = 0; c < 7; c++) begin
      cyc();
      if (div_tick != 0 || pdiv_tick) hits++;
    end
    chk("frozen_ticks", hits, 0);
    en = 1'b1;
    for (int c = 0; c < 5; c++) cyc();

    // Reset with a load pending.
    div_val = 8'd5; load = 1'b1; cyc(); load = 1'b0;
    do_reset();
    chk("reset_drops_busy", int'(busy), 0);
    chk("reset_drops_pdiv", int'(pdiv_out), 0);
    for (int c = 0; c < 10; c++) cyc();

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      en    = ($urandom_range(0, 9) < 8);
      load  = ($urandom_range(0, 39) == 0);
      div_val = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3))
                                            : W'($urandom_range(0, 40));
      if ($urandom_range(0, 15) == 0) mask = S'($urandom);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Fully synchronous, parametrised clock-divider bank replacing ripple-clocked divide-by-2/4/8/16 flops. A single free-running counter yields STAGES binary-ratio square waves plus one-cycle rising-edge strobes, a masked AND-combine output, and one programmable divide-by-N channel with glitch-free ratio change. All outputs are data signals in the `clk` domain, intended as clock enables for downstream logic, never as clocks.

## Interface
- STAGES, 4, number of binary divider stages (1..16); stage k divides by 2^(k+1)
- DIV_W, 8, width of programmable ratio N (2..16)
- DEFAULT_DIV, 10, active N after reset (2..2^DIV_W-1)

- clk  in  1  sole clock, all logic on rising edge
- reset  in  1  synchronous, active-high; dominates every other input
- en  in  1  count enable; 0 freezes all counters
- mask  in  STAGES  stage select for y
- div_val  in  DIV_W  requested programmable ratio N
- load  in  1  capture div_val into pending register
- div_out  out  STAGES  binary-ratio square waves, 50% duty
- div_tick  out  STAGES  one-cycle strobe on each rising edge of div_out[k]
- y  out  1  AND of div_out bits selected by mask
- pdiv_out  out  1  programmable divide-by-N wave
- pdiv_tick  out  1  one-cycle strobe on each rising edge of pdiv_out
- busy  out  1  pending ratio not yet applied

## Operation
- Binary bank: STAGES-bit counter cnt, +1 per cycle with en=1, wraps 2^STAGES-1 -> 0. div_out[k] = cnt[k]; period 2^(k+1) enabled cycles.
- div_tick[k] = 1 exactly in the cycle div_out[k] first reads 1 after a 0; never when en was 0 in the preceding edge.
- y = AND over k with mask[k]=1 of div_out[k], evaluated on the same registered cnt value as div_out; mask = 0 forces y = 0.
- Programmable channel: counter pcnt 0..N-1, +1 per enabled cycle, wraps N-1 -> 0. pdiv_out = (pcnt >= floor(N/2)): low floor(N/2) cycles, high ceil(N/2) cycles. pdiv_tick = 1 in the first cycle pcnt = floor(N/2).
- Ratio change: load=1 captures div_val into pending (div_val < 2 clamped to 2), busy=1 from next cycle. Pending becomes active N on the enabled wrap edge N-1 -> 0; busy drops in the same cycle. No truncated or stretched period ever emitted.
- load while busy: pending overwritten, latest wins. load coincident with a wrap edge: value captured, applied at the following wrap, not this one.
- en=0: cnt, pcnt, div_out, y, pdiv_out hold; all ticks 0; load still captured, but application waits for an enabled wrap.

## Timing
- All outputs registered; no combinational path input -> output.
- Reset values: cnt=0, pcnt=0, div_out=0, div_tick=0, y=0, pdiv_out=0, pdiv_tick=0, busy=0, active N=DEFAULT_DIV, pending cleared.
- Reset mid-operation: all of the above in the cycle after the reset edge; pending load discarded.
- Latency: edge c after reset release with en=1 continuously gives cnt=c mod 2^STAGES; mask change visible on y one cycle later.
- pdiv first rising edge at enabled cycle floor(N/2) after reset.

## Test plan
- STAGES=4, reset then en=1 for 40 cycles -> div_out[0] toggles every cycle; div_out[3] first high at cycle 8, period 16; div_tick[3] only at cycles 8, 24, 40.
- mask=4'b0101, en=1 -> y high only when cnt ∈ {5,7,13,15}; mask=0 -> y stays 0.
- DEFAULT_DIV=10 -> pdiv_out low 5, high 5, pdiv_tick once per period; load div_val=3 at pcnt=4 -> busy high until wrap, then low 1 / high 2 with no short pulse.
- div_val=0 -> behaves as N=2 (alternating); div_val=255 -> period 255, low 127, high 128.
- Two loads (6 then 7) while busy -> only N=7 applied at next wrap; load on wrap edge applied one period later.
- en=0 for 7 cycles mid-run -> all outputs hold, ticks 0; reset asserted with load pending -> all outputs 0, busy 0, N=10 next cycle.
